// File: rtl/gshare_predictor.sv
// gshare direction predictor: 2-bit counters indexed by PC ^ global history.
// Registered fetch lookup, commit-side training and mispredict history repair.
module gshare_predictor #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6,
    parameter int GHR_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lookup_valid,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             update_valid,
    input  logic [PC_W-1:0]  update_pc,
    input  logic [GHR_W-1:0] update_ghr,
    input  logic             update_taken,
    input  logic             update_mispredict
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       cnt [DEPTH];
    logic [GHR_W-1:0] ghr;
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;
    logic             lookup_bit;
    logic [1:0]       old_cnt;
    logic [1:0]       trained;
    logic [GHR_W-1:0] spec_ghr;
    logic [GHR_W-1:0] repair_ghr;
    logic             squash;
    logic             accept;
    logic             unused_bits;

    assign lookup_idx = lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr);
    assign update_idx = update_pc[IDX_W+1:2] ^ IDX_W'(update_ghr);
    assign lookup_bit = cnt[lookup_idx][1];
    assign old_cnt    = cnt[update_idx];

    // Casting the concatenation drops the oldest bit; also covers GHR_W == 1.
    assign spec_ghr   = GHR_W'({ghr, lookup_bit});
    assign repair_ghr = GHR_W'({update_ghr, update_taken});

    assign squash = update_valid & update_mispredict;
    assign accept = lookup_valid & ~squash;

    always_comb begin
        trained = old_cnt;
        if (update_taken) begin
            if (old_cnt != 2'b11) trained = old_cnt + 2'b01;
        end else begin
            if (old_cnt != 2'b00) trained = old_cnt - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) cnt[i] <= 2'b01;
            ghr        <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_ghr   <= '0;
        end else begin
            pred_valid <= accept;
            if (accept) begin
                pred_taken <= lookup_bit;
                pred_ghr   <= ghr;
            end
            if (squash) ghr <= repair_ghr;
            else if (lookup_valid) ghr <= spec_ghr;
            if (update_valid) cnt[update_idx] <= trained;
        end
    end

    assign unused_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                           update_pc[PC_W-1:IDX_W+2], update_pc[1:0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor.
// Linear stimulus with hand-computed expectations and immediate assertions.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_valid;
    logic        pred_taken;
    logic [5:0]  pred_ghr;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = '0;
    logic [5:0]  update_ghr = '0;
    logic        update_taken = 1'b0;
    logic        update_mispredict = 1'b0;

    int vectors = 0;
    int errors  = 0;

    gshare_predictor #(.PC_W(32), .IDX_W(6), .GHR_W(6)) dut (
        .clk               (clk),
        .reset             (reset),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .pred_valid        (pred_valid),
        .pred_taken        (pred_taken),
        .pred_ghr          (pred_ghr),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_ghr        (update_ghr),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic [5:0] g,
                       input logic t, input logic mp);
        update_valid      = 1'b1;
        update_pc         = pc;
        update_ghr        = g;
        update_taken      = t;
        update_mispredict = mp;
    endtask

    task automatic idle();
        lookup_valid      = 1'b0;
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
    endtask

    initial begin
        // reset
        tick();
        tick();
        reset = 1'b0;
        check("rst_pred_valid", 32'(pred_valid), 0);
        check("rst_pred_taken", 32'(pred_taken), 0);
        check("rst_pred_ghr", 32'(pred_ghr), 0);
        check("rst_ghr", 32'(dut.ghr), 0);
        check("rst_cnt10", 32'(dut.cnt[16]), 1);

        // test 1: first lookup
        lookup_valid = 1'b1;
        lookup_pc    = 32'h40;
        tick();
        idle();
        check("t1_pred_valid", 32'(pred_valid), 1);
        check("t1_pred_taken", 32'(pred_taken), 0);
        check("t1_pred_ghr", 32'(pred_ghr), 0);
        check("t1_ghr", 32'(dut.ghr), 0);
        tick();
        check("t1_idle_valid", 32'(pred_valid), 0);

        // test 2: taken training saturates
        upd(32'h40, 6'h00, 1'b1, 1'b0);
        tick();
        check("t2_cnt_a", 32'(dut.cnt[16]), 2);
        tick();
        check("t2_cnt_b", 32'(dut.cnt[16]), 3);
        tick();
        check("t2_cnt_sat", 32'(dut.cnt[16]), 3);
        check("t2_ghr", 32'(dut.ghr), 0);

        // test 3: mispredict repair then not-taken saturation
        upd(32'h40, 6'h00, 1'b0, 1'b1);
        tick();
        check("t3_cnt_mp", 32'(dut.cnt[16]), 2);
        check("t3_ghr", 32'(dut.ghr), 0);
        upd(32'h40, 6'h00, 1'b0, 1'b0);
        tick();
        check("t3_cnt_a", 32'(dut.cnt[16]), 1);
        tick();
        check("t3_cnt_b", 32'(dut.cnt[16]), 0);
        tick();
        check("t3_cnt_sat", 32'(dut.cnt[16]), 0);

        // test 4: train up, then two back-to-back lookups
        upd(32'h40, 6'h00, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        idle();
        check("t4_cnt", 32'(dut.cnt[16]), 3);
        lookup_valid = 1'b1;
        lookup_pc    = 32'h40;
        tick();
        check("t4_l1_valid", 32'(pred_valid), 1);
        check("t4_l1_taken", 32'(pred_taken), 1);
        check("t4_l1_pghr", 32'(pred_ghr), 0);
        check("t4_l1_ghr", 32'(dut.ghr), 1);
        tick();
        idle();
        check("t4_l2_valid", 32'(pred_valid), 1);
        check("t4_l2_taken", 32'(pred_taken), 0);
        check("t4_l2_pghr", 32'(pred_ghr), 1);
        check("t4_l2_ghr", 32'(dut.ghr), 2);

        // repair GHR to 0 and bring counter 0x10 back to 01
        upd(32'h40, 6'h00, 1'b0, 1'b1);
        tick();
        check("t5_prep_ghr", 32'(dut.ghr), 0);
        upd(32'h40, 6'h00, 1'b0, 1'b0);
        tick();
        idle();
        check("t5_prep_cnt", 32'(dut.cnt[16]), 1);

        // test 5: same-index lookup and update, read-before-write
        lookup_valid = 1'b1;
        lookup_pc    = 32'h40;
        upd(32'h40, 6'h00, 1'b1, 1'b0);
        tick();
        idle();
        check("t5_valid", 32'(pred_valid), 1);
        check("t5_taken_old", 32'(pred_taken), 0);
        check("t5_cnt_new", 32'(dut.cnt[16]), 2);
        check("t5_ghr", 32'(dut.ghr), 0);

        // test 6: lookup squashed by mispredict repair
        lookup_valid = 1'b1;
        lookup_pc    = 32'h40;
        upd(32'h00, 6'h15, 1'b1, 1'b1);
        tick();
        idle();
        check("t6_squash_valid", 32'(pred_valid), 0);
        check("t6_repair_ghr", 32'(dut.ghr), 32'h2b);
        check("t6_cnt15", 32'(dut.cnt[21]), 2);

        // reset mid-stream with a lookup in flight
        lookup_valid = 1'b1;
        reset        = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check("t6_rst_valid", 32'(pred_valid), 0);
        check("t6_rst_ghr", 32'(dut.ghr), 0);
        check("t6_rst_pghr", 32'(pred_ghr), 0);
        for (int i = 0; i < 64; i++) check("t6_rst_cnt", 32'(dut.cnt[i]), 1);

        // post-reset lookup sees weak-NT
        lookup_valid = 1'b1;
        lookup_pc    = 32'h40;
        tick();
        idle();
        check("post_valid", 32'(pred_valid), 1);
        check("post_taken", 32'(pred_taken), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
